// File: rtl/dymfns_decoder_9x9_seq.sv
// Sequential 9x9 Dy-MFNS receive decoder: one shared Fibonacci-weight group
// decoder walks the nine codeword groups, one per cycle, behind valid/ready.
module dymfns_decoder_9x9_seq #(
    parameter int NUM_GROUPS = 9,
    parameter int GROUP_W    = 9,
    parameter int DATA_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cw_valid,
    output logic        cw_ready,
    input  logic [80:0] cw_in,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [53:0] data_out,
    output logic [8:0]  err_out,
    output logic        busy
);

    localparam int CW_W  = NUM_GROUPS * GROUP_W;
    localparam int OUT_W = NUM_GROUPS * DATA_W;
    localparam logic [3:0] LAST_GRP = 4'(NUM_GROUPS - 1);
    localparam logic [6:0] WEIGHT [GROUP_W] = '{7'd1, 7'd1, 7'd2, 7'd3, 7'd5,
                                                 7'd8, 7'd13, 7'd21, 7'd34};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [CW_W-1:0]         cw_q, cw_d;
    logic [OUT_W-1:0]        data_q, data_d;
    logic [NUM_GROUPS-1:0]   err_q, err_d;
    logic                    cw_ready_q, cw_ready_d;
    logic                    data_valid_q, data_valid_d;

    logic [GROUP_W-1:0]      grp_arr [NUM_GROUPS];
    logic [GROUP_W-1:0]      grp_sel;
    logic [6:0]              term [GROUP_W];
    logic [6:0]              grp_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_split
            assign grp_arr[gi] = cw_q[gi*GROUP_W +: GROUP_W];
        end
    endgenerate

    assign grp_sel = (cnt_q <= LAST_GRP) ? grp_arr[cnt_q] : '0;

    generate
        for (gi = 0; gi < GROUP_W; gi++) begin : g_term
            assign term[gi] = grp_sel[gi] ? WEIGHT[gi] : 7'd0;
        end
    endgenerate

    // Max weighted sum is 88, so 7 bits never overflow.
    always_comb begin
        grp_sum = 7'd0;
        for (int i = 0; i < GROUP_W; i++) begin
            grp_sum = grp_sum + term[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cw_d         = cw_q;
        data_d       = data_q;
        err_d        = err_q;
        cw_ready_d   = cw_ready_q;
        data_valid_d = data_valid_q;
        case (state_q)
            IDLE: begin
                cw_ready_d   = 1'b1;
                data_valid_d = 1'b0;
                if (cw_valid && cw_ready_q) begin
                    cw_d       = cw_in;
                    data_d     = '0;
                    err_d      = '0;
                    cnt_d      = 4'd0;
                    cw_ready_d = 1'b0;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                cw_ready_d = 1'b0;
                if (cnt_q > LAST_GRP) begin
                    cnt_d      = 4'd0;
                    cw_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    for (int k = 0; k < NUM_GROUPS; k++) begin
                        if (cnt_q == 4'(k)) begin
                            data_d[k*DATA_W +: DATA_W] = grp_sum[DATA_W-1:0];
                            err_d[k]                   = (grp_sum > 7'd63);
                        end
                    end
                    if (cnt_q == LAST_GRP) begin
                        cnt_d        = 4'd0;
                        data_valid_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                data_valid_d = 1'b1;
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    cw_ready_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                cnt_d        = 4'd0;
                cw_ready_d   = 1'b1;
                data_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            cw_q         <= '0;
            data_q       <= '0;
            err_q        <= '0;
            cw_ready_q   <= 1'b1;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cw_q         <= cw_d;
            data_q       <= data_d;
            err_q        <= err_d;
            cw_ready_q   <= cw_ready_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign cw_ready   = cw_ready_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_q;
    assign err_out    = err_q;
    assign busy       = (state_q == DECODE) || (state_q == DONE);

endmodule

// File: tb/tb_dymfns_decoder_9x9_seq.sv
// Scoreboard bench for the sequential Dy-MFNS decoder: the driver queues
// hand-computed results, a negedge monitor checks them and the latency.
module tb_dymfns_decoder_9x9_seq;

    logic        clk;
    logic        rst;
    logic        cw_valid;
    logic        cw_ready;
    logic [80:0] cw_in;
    logic        data_valid;
    logic        data_ready;
    logic [53:0] data_out;
    logic [8:0]  err_out;
    logic        busy;

    typedef struct packed {
        logic [53:0] d;
        logic [8:0]  e;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    dymfns_decoder_9x9_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .cw_in      (cw_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_out   (data_out),
        .err_out    (err_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: latency on each data_valid rise, scoreboard pop on each accepted result.
    initial begin : monitor
        int   accept_cyc;
        logic prev_dv;
        exp_t e;
        accept_cyc = 0;
        prev_dv    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cw_valid && cw_ready) accept_cyc = cyc + 1;
                if (data_valid && !prev_dv) check("latency", 64'(cyc), 64'(accept_cyc + 9));
                if (data_valid && data_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_output: got data %h err %h expected none", data_out, err_out);
                    end else begin
                        e = sb_q.pop_front();
                        $display("txn: data_out=%h err_out=%b (expected %h %b)", data_out, err_out, e.d, e.e);
                        check("data_out", 64'(data_out), 64'(e.d));
                        check("err_out", 64'(err_out), 64'(e.e));
                    end
                end
            end
            prev_dv = data_valid;
        end
    end

    task automatic send(input logic [80:0] cw, input logic [53:0] d, input logic [8:0] e);
        int n;
        n = 0;
        while (!cw_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cw_ready) begin
            check("cw_ready_timeout", 64'(cw_ready), 64'd1);
        end else begin
            cw_in    = cw;
            cw_valid = 1'b1;
            sb_q.push_back('{d: d, e: e});
            @(posedge clk); #1;
            cw_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : driver
        logic [80:0] cw;
        logic [53:0] d;
        int          n;
        logic [5:0]  fib [9];
        fib = '{6'd1, 6'd1, 6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34};

        rst        = 1'b1;
        cw_valid   = 1'b0;
        cw_in      = '0;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cw_ready", 64'(cw_ready), 64'd1);
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_err_out", 64'(err_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send(81'h0, 54'h0, 9'h0);
        send({9{9'h1A0}}, 54'h3F_FFFF_FFFF_FFFF, 9'h0);
        send((81'h100 << 72) | 81'h1, 54'h22_0000_0000_0001, 9'h0);
        send(81'h1FF << 36, 54'h0000_0018_000000, 9'b000010000);
        send((81'h1C0 << 63) | (81'h0FF << 18), (54'd4 << 42) | (54'd54 << 12), 9'b010000000);
        cw = '0;
        d  = '0;
        for (int k = 0; k < 9; k++) begin
            cw[10*k]       = 1'b1;
            d[6*k +: 6]    = fib[k];
        end
        send(cw, d, 9'h0);
        drain();

        // Sink stalls for five cycles in DONE; a stray cw_valid must be ignored.
        data_ready = 1'b0;
        send({9{9'h1A0}}, 54'h3F_FFFF_FFFF_FFFF, 9'h0);
        n = 0;
        while (!data_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_dv_rise", 64'(data_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("hold_data_valid", 64'(data_valid), 64'd1);
            check("hold_data_out", 64'(data_out), 64'h3F_FFFF_FFFF_FFFF);
            check("hold_err_out", 64'(err_out), 64'd0);
            check("hold_cw_ready", 64'(cw_ready), 64'd0);
            if (i == 1) begin
                cw_in    = '1;
                cw_valid = 1'b1;
            end else begin
                cw_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        cw_valid   = 1'b0;
        data_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        check("no_spurious_accept", 64'(busy), 64'd0);

        // Reset during the fourth DECODE cycle discards the partial word.
        send((81'h100 << 72) | 81'h1, 54'h22_0000_0000_0001, 9'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_data_valid", 64'(data_valid), 64'd0);
        check("mid_rst_cw_ready", 64'(cw_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data_out", 64'(data_out), 64'd0);
        check("mid_rst_err_out", 64'(err_out), 64'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_cw_ready", 64'(cw_ready), 64'd1);
        send((81'h100 << 72) | 81'h1, 54'h22_0000_0000_0001, 9'h0);
        drain();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
